// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver.
// A two-flop synchroniser feeds a mid-bit sampling FSM. Received bytes are
// offered on a valid/ready port. The receiver also rejects glitches shorter
// than half a bit, flags framing errors and flags overruns.
//
// Handshake: rx_data is transferred on any rising int_clk edge where
// rx_valid && rx_ready. Once rx_valid is high, it stays high and rx_data stays
// stable until that transfer happens. A new byte may replace the old one in the
// same cycle as the transfer, and rx_valid then stays high.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       int_clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  logic             sync_1;
  logic             rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             deliver_pend;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge int_clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= din;
      rx_s   <= sync_1;
    end
  end

  // Frame FSM, bit timing, delivery/consume handshake and error pulses
  always_ff @(posedge int_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      deliver_pend <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      deliver_pend <= 1'b0;

      // Deliver the byte one cycle after a good stop sample. The slot is free
      // if it is empty or is being consumed in this same cycle.
      if (deliver_pend) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // The start bit was not low at its midpoint, so treat it as a glitch
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              deliver_pend <= 1'b1;
              state        <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // A line held low (break) waits here and gives only one frame_err
          bit_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. It is the downstream counterpart of the team's UART transmitter, and its `din` connects directly to the transmitter's `dout`.
- It decodes 8N1 frames: idle high, one start bit (0), eight data bits LSB first, one stop bit (1).
- Each byte is presented on a valid/ready interface to the consuming logic.
- It also provides glitch rejection, framing-error detection and overrun detection.

Parameters:
- CLKS_PER_BIT, 5208, int_clk cycles per bit (50 MHz / 9600 baud); legal range 4 and up.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit mid-sample.

Ports:
- int_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- din  in  1  asynchronous serial line input; idle high.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a byte is dropped because the previous one was unconsumed.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **Reset** (rst_n=0 at a rising edge): state=IDLE, both synchroniser flops=1, counters=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. Reset applied mid-frame abandons the frame with no error pulse.
- **Input synchroniser:** din passes through two flops to form rx_s. All decisions use rx_s only.
- **Counter:** bit_cnt counts cycles within the current state. It clears on every state transition. Width is ceil(log2(CLKS_PER_BIT)).
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** rx_s=0 moves to START.
- **START:** at bit_cnt==HALF_BIT-1, sample rx_s.
  - rx_s=0: go to DATA with bit_idx=0.
  - rx_s=1: treat as a glitch and return to IDLE. No outputs change.
- **DATA:** at bit_cnt==CLKS_PER_BIT-1 (mid-bit), shift rx_s into shift_reg[bit_idx]. Data is LSB first.
  - bit_idx increments after each sample.
  - After the sample with bit_idx==7, go to STOP.
- **STOP:** at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: perform delivery (below), then go to IDLE. The next start edge may begin during the second half of the stop bit.
  - rx_s=0: pulse frame_err for one cycle, discard shift_reg, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until rx_s=1, then go to IDLE. This covers break conditions and produces no repeated frame_err.
- **Delivery:** performed in the cycle after a good stop sample.
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: rx_data<=shift_reg and rx_valid<=1. A simultaneous consume and new byte gives no overrun and leaves rx_valid high.
  - Otherwise: rx_data and rx_valid are held, the new byte is dropped, and overrun pulses high for one cycle.
- **Consume:** rx_valid && rx_ready with no delivery that cycle clears rx_valid the next cycle. rx_data keeps its last value.
- **Latency:** rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after din's falling start edge, with a tolerance of ±2 cycles.
- **Sampling tolerance:** mid-bit sampling tolerates at least ±4% baud mismatch.

Test Plan (CLKS_PER_BIT=16, rx_ready=1 unless noted):
- Drive frame 0xA5 on din (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> rx_data=0xA5, rx_valid high for one cycle, rising 155±2 cycles after the start edge; frame_err=0, overrun=0.
- Drive din low for 4 cycles, then high -> busy pulses, FSM returns to IDLE, no rx_valid, no frame_err.
- Drive frame 0x3C with stop bit 0, holding din low for a further 40 cycles -> frame_err pulses once, rx_valid stays 0, busy stays high until din returns high; a following 0x81 frame is received correctly.
- With rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 with rx_valid=1; overrun pulses once at the 0x22 stop sample; rx_data stays 0x11; raising rx_ready clears rx_valid.
- Send back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three rx_valid pulses carrying 0x00, 0xFF, 0x55 in order; no errors.
- Assert rst_n=0 mid-way through the data bits of frame 0x77, then release and send 0x0F -> all outputs reset during reset, no pulse for the aborted frame, 0x0F received correctly.
